// File: rtl/max_product_backward_sequencer.sv
// Backward-pass sequencer for the max-product beta/LLR stage.
// Buffers one frame of alpha and branch metrics in forward order. It then
// replays them last-first, one symbol per stage transaction. It feeds each
// returned beta back as the next OldBetaMetric and tags each LLR pair with
// its symbol index. Metric words are opaque here.
// Optional build macro: TERMINATED_TRELLIS_EN. When defined, the initial beta
// forces the end state to 0. When undefined, all end states are equiprobable.
module max_product_backward_sequencer #(
  parameter int unsigned  BITS            = 16,
  parameter int unsigned  STATES          = 4,
  parameter int unsigned  OUTPUT_SYMBOLS  = 4,
  parameter int unsigned  BITS_PER_SYMBOL = 2,
  parameter int unsigned  FRAME_SYMBOLS   = 64,
  parameter logic [BITS-1:0] NEG_INIT     = 16'hFC00,
  localparam int unsigned AW              = $clog2(FRAME_SYMBOLS)
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      in_last,
  input  logic [STATES-1:0][BITS-1:0]               in_alpha,
  input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]       in_branch,
  output logic                                      stage_valid,
  output logic [STATES-1:0][BITS-1:0]               stage_alpha,
  output logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]       stage_branch,
  output logic [STATES-1:0][BITS-1:0]               stage_old_beta,
  input  logic                                      stage_done,
  input  logic [STATES-1:0][BITS-1:0]               stage_beta,
  input  logic [BITS_PER_SYMBOL-1:0][BITS-1:0]      stage_llr,
  output logic                                      llr_valid,
  output logic [BITS_PER_SYMBOL-1:0][BITS-1:0]      llr,
  output logic [AW-1:0]                             llr_index,
  output logic                                      frame_done,
  output logic                                      overflow_err
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned MW = BITS * (STATES + OUTPUT_SYMBOLS);

  typedef enum logic [2:0] {
    S_FILL,
    S_READ,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                    state, state_d;
  logic [MW-1:0]             mem [FRAME_SYMBOLS];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic                      first;
  logic [STATES-1:0][BITS-1:0] beta_reg;
  logic [STATES-1:0][BITS-1:0] init_beta;
  logic                      accept;
  logic                      store;
  logic                      take_done;

  assign accept    = (state == S_FILL) && in_ready && in_valid;
  assign store     = accept && (count != CW'(FRAME_SYMBOLS));
  assign take_done = (state == S_WAIT) && stage_done;

  // Beta vector that seeds the recursion at the end of the frame.
  always_comb begin
    init_beta = '0;
`ifdef TERMINATED_TRELLIS_EN
    for (int s = 1; s < int'(STATES); s++) begin
      init_beta[s] = NEG_INIT;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_FILL;
    else       state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_FILL:  if (accept && in_last) state_d = S_READ;
      S_READ:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (stage_done) state_d = (rd_ptr == '0) ? S_DONE : S_READ;
      S_DONE:  state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Frame buffer; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= {in_branch, in_alpha};
  end

  // Pointers, stage interface registers and LLR tagging.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready       <= 1'b0;
      stage_valid    <= 1'b0;
      stage_alpha    <= '0;
      stage_branch   <= '0;
      stage_old_beta <= '0;
      llr_valid      <= 1'b0;
      llr            <= '0;
      llr_index      <= '0;
      frame_done     <= 1'b0;
      overflow_err   <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      first          <= 1'b0;
      beta_reg       <= '0;
    end else begin
      // in_ready stays low through the frame_done cycle.
      in_ready    <= (state_d == S_FILL) && (state != S_DONE);
      stage_valid <= (state_d == S_ISSUE);
      llr_valid   <= take_done;
      frame_done  <= (state == S_DONE);

      if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
      if (accept && !store) overflow_err <= 1'b1;
      if (accept && in_last) begin
        rd_ptr <= store ? wr_ptr : wr_ptr - AW'(1);
        first  <= 1'b1;
      end

      // The stage registers double as the RAM read register.
      if (state == S_READ) begin
        {stage_branch, stage_alpha} <= mem[rd_ptr];
        stage_old_beta              <= first ? init_beta : beta_reg;
      end
      if (state == S_ISSUE) first <= 1'b0;

      if (take_done) begin
        beta_reg  <= stage_beta;
        llr       <= stage_llr;
        llr_index <= rd_ptr;
        if (rd_ptr != '0) rd_ptr <= rd_ptr - AW'(1);
      end

      if (state == S_DONE) begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_max_product_backward_sequencer.sv
// Scoreboard bench for max_product_backward_sequencer: expected stage issues,
// tagged LLRs and frame_done pulses are queued at stimulus time and checked by
// an independent monitor.
module tb_max_product_backward_sequencer;

  typedef logic [3:0][15:0] vec4_t;
  typedef logic [1:0][15:0] llr2_t;
  typedef struct packed { vec4_t alpha; vec4_t branch; vec4_t beta; } iss_t;
  typedef struct packed { llr2_t llr; logic [5:0] idx; } out_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, in_last;
  vec4_t       in_alpha, in_branch;
  logic        stage_valid;
  vec4_t       stage_alpha, stage_branch, stage_old_beta;
  logic        stage_done;
  vec4_t       stage_beta;
  llr2_t       stage_llr;
  logic        llr_valid;
  llr2_t       llr;
  logic [5:0]  llr_index;
  logic        frame_done, overflow_err;

  int   checks = 0;
  int   errors = 0;
  iss_t exp_iss[$];
  out_t exp_out[$];
  int   exp_fd = 0;
  bit   prev_idx0 = 1'b0;
  iss_t e_iss;
  out_t e_out;

  max_product_backward_sequencer dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_alpha(in_alpha), .in_branch(in_branch),
    .stage_valid(stage_valid), .stage_alpha(stage_alpha),
    .stage_branch(stage_branch), .stage_old_beta(stage_old_beta),
    .stage_done(stage_done), .stage_beta(stage_beta), .stage_llr(stage_llr),
    .llr_valid(llr_valid), .llr(llr), .llr_index(llr_index),
    .frame_done(frame_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec4_t alpha_of(input int k);
    vec4_t v;
    for (int s = 0; s < 4; s++) v[s] = 16'h3C00 + 16'(k) + 16'(s * 256);
    return v;
  endfunction

  function automatic vec4_t branch_of(input int k);
    vec4_t v;
    for (int b = 0; b < 4; b++) v[b] = 16'(4096 * (b + 1)) + 16'(k);
    return v;
  endfunction

  // Beta returned at the j-th stage completion of a frame.
  function automatic vec4_t resp_beta(input int j);
    vec4_t v;
    v[0] = 16'h3C00 + 16'(j);
    v[1] = 16'h4000 + 16'(j);
    v[2] = 16'h4200 + 16'(j);
    v[3] = 16'h4400 + 16'(j);
    return v;
  endfunction

  function automatic llr2_t resp_llr(input int j);
    llr2_t v;
    v[0] = 16'hA000 + 16'(j);
    v[1] = 16'hB100 + 16'(j);
    return v;
  endfunction

  function automatic vec4_t init_exp();
    vec4_t v;
`ifdef TERMINATED_TRELLIS_EN
    v[0] = 16'h0000; v[1] = 16'hFC00; v[2] = 16'hFC00; v[3] = 16'hFC00;
`else
    v = '0;
`endif
    return v;
  endfunction

  // Monitor: compare every DUT presentation against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (stage_valid) begin
        if (exp_iss.size() == 0) begin
          chk("unexpected_issue", 64'd1, 64'd0);
        end else begin
          e_iss = exp_iss.pop_front();
          chk("issue_alpha", stage_alpha, e_iss.alpha);
          chk("issue_branch", stage_branch, e_iss.branch);
          chk("issue_old_beta", stage_old_beta, e_iss.beta);
        end
      end
      if (llr_valid) begin
        if (exp_out.size() == 0) begin
          chk("unexpected_llr_valid", 64'd1, 64'd0);
        end else begin
          e_out = exp_out.pop_front();
          chk("llr_value", 64'(llr), 64'(e_out.llr));
          chk("llr_index", 64'(llr_index), 64'(e_out.idx));
        end
      end
      if (frame_done) begin
        chk("frame_done_expected", 64'(exp_fd > 0), 64'd1);
        chk("frame_done_after_idx0", 64'(prev_idx0), 64'd1);
        if (exp_fd > 0) exp_fd--;
      end
      prev_idx0 = llr_valid && (llr_index == 6'd0);
    end else begin
      prev_idx0 = 1'b0;
    end
  end

  task automatic send_frame(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_alpha  = alpha_of(k);
      in_branch = branch_of(k);
      in_last   = (k == n - 1);
      chk("in_ready_fill", 64'(in_ready), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    int t = 0;
    while (!stage_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = stage_valid;
    if (!ok) chk("issue_timeout", 64'd1, 64'd0);
  endtask

  // Stage model: answer each issue 5 cycles later; spur adds misuse.
  task automatic serve(input int m, input bit spur);
    bit ok;
    for (int j = 0; j < m; j++) begin
      wait_issue(ok);
      if (!ok) return;
      if (spur && j < m - 1) begin
        in_valid  = 1'b1;
        in_alpha  = 64'hDEAD_DEAD_DEAD_DEAD;
        in_branch = 64'hBEEF_BEEF_BEEF_BEEF;
        @(negedge clk);
        chk("in_ready_wait", 64'(in_ready), 64'd0);
        repeat (4) @(negedge clk);
      end else begin
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
      end
      if (j == m - 1) in_valid = 1'b0;
      stage_done = 1'b1;
      stage_beta = resp_beta(j);
      stage_llr  = resp_llr(j);
      @(negedge clk);
      if (spur) begin
        stage_beta = 64'h7777_7777_7777_7777;
        stage_llr  = 32'h6666_6666;
        @(negedge clk);
      end
      stage_done = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frame_done();
    int t = 0;
    while (!frame_done && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!frame_done) chk("frame_done_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_frame(input int n, input bit spur);
    int m;
    m = (n > 64) ? 64 : n;
    for (int j = 0; j < m; j++) begin
      exp_iss.push_back({alpha_of(m - 1 - j), branch_of(m - 1 - j),
                         (j == 0) ? init_exp() : resp_beta(j - 1)});
      exp_out.push_back({resp_llr(j), 6'(m - 1 - j)});
    end
    exp_fd++;
    send_frame(n);
    serve(m, spur);
    wait_frame_done();
  endtask

  initial begin
    bit ok;
    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_alpha = '0; in_branch = '0;
    stage_done = 1'b0; stage_beta = '0; stage_llr = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_stage_valid", 64'(stage_valid), 64'd0);
    chk("rst_llr_valid", 64'(llr_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_stage_old_beta", stage_old_beta, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_frame(3, 1'b0);
    run_frame(1, 1'b0);

    // Spurious stage_done while idle in FILL must not produce an LLR.
    @(negedge clk);
    stage_done = 1'b1; stage_beta = 64'h1111_2222_3333_4444; stage_llr = 32'h5555_5555;
    @(negedge clk);
    stage_done = 1'b0;
    @(negedge clk);
    chk("spur_fill_llr_valid", 64'(llr_valid), 64'd0);

    // Extra done cycle lands in READ; junk in_valid offered during WAIT.
    run_frame(3, 1'b1);
    chk("overflow_clear", 64'(overflow_err), 64'd0);

    run_frame(65, 1'b0);
    chk("overflow_set", 64'(overflow_err), 64'd1);
    run_frame(1, 1'b0);
    chk("overflow_sticky", 64'(overflow_err), 64'd1);

    // Reset while the stage is busy.
    exp_iss.push_back({alpha_of(1), branch_of(1), init_exp()});
    send_frame(2);
    wait_issue(ok);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_iss.delete();
    exp_out.delete();
    exp_fd = 0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_stage_valid", 64'(stage_valid), 64'd0);
    chk("mid_rst_llr_valid", 64'(llr_valid), 64'd0);
    chk("mid_rst_overflow", 64'(overflow_err), 64'd0);
    repeat (10) @(negedge clk);

    chk("iss_queue_empty", 64'(exp_iss.size()), 64'd0);
    chk("llr_queue_empty", 64'(exp_out.size()), 64'd0);
    chk("frame_done_pending", 64'(exp_fd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
